// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath: lane width, lane type
// and the input feeder state encoding.
package systolic_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {LOAD, STREAM} feeder_state_t;

  typedef logic [DATA_W-1:0] lane_t;

endpackage

// File: rtl/feeder_tile_buffer.sv
// Tile storage for the input feeder: one row-vector write port and a
// combinational skewed read, where lane j returns row (step - j) or zero.
module feeder_tile_buffer
  import systolic_pkg::*;
#(
  parameter int num_rows = 8,
  parameter int num_cols = 8,
  parameter int ADDR_W   = 4,
  parameter int STEP_W   = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_waddr,
  input  logic [DATA_W*num_cols-1:0] i_wdata,
  input  logic [STEP_W-1:0]        i_step,
  output logic [DATA_W*num_cols-1:0] o_lanes
);

  lane_t r_mem [num_rows][num_cols];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int unsigned r = 0; r < num_rows; r++) begin
        if (i_waddr == ADDR_W'(r)) begin
          for (int unsigned j = 0; j < num_cols; j++) begin
            r_mem[r][j] <= i_wdata[DATA_W*j +: DATA_W];
          end
        end
      end
    end
  end

  // Matching step == r + j avoids a subtraction; no match leaves the zero pad.
  always_comb begin
    o_lanes = '0;
    for (int unsigned j = 0; j < num_cols; j++) begin
      for (int unsigned r = 0; r < num_rows; r++) begin
        if (i_step == STEP_W'(r + j)) begin
          o_lanes[DATA_W*j +: DATA_W] = r_mem[r][j];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_input_feeder.sv
// Loads one tile of row-vectors over valid/ready, then replays it with lane j
// delayed by j cycles to form the array's input wavefront.
module systolic_input_feeder
  import systolic_pkg::*;
#(
  parameter int num_rows = 8,
  parameter int num_cols = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W*num_cols-1:0] in_data,
  output logic [DATA_W*num_cols-1:0] out_stream,
  output logic                       out_valid,
  output logic                       out_first,
  output logic                       out_last,
  output logic                       busy
);

  localparam int S      = num_rows + num_cols - 1;
  localparam int BEAT_W = $clog2(num_rows + 1);
  localparam int STEP_W = $clog2(S + 1);

  feeder_state_t r_state, w_state_nxt;
  logic [BEAT_W-1:0] r_beat_cnt, w_beat_nxt;
  logic [STEP_W-1:0] r_step_cnt, w_step_nxt;
  logic [DATA_W*num_cols-1:0] w_lanes;
  logic [DATA_W*num_cols-1:0] r_out_stream;
  logic r_out_valid, r_out_first, r_out_last;
  logic w_accept;

  assign in_ready = (r_state == LOAD);
  assign w_accept = in_valid && (r_state == LOAD);
  assign busy     = (r_state != LOAD) || (r_beat_cnt != '0);

  feeder_tile_buffer #(
    .num_rows (num_rows),
    .num_cols (num_cols),
    .ADDR_W   (BEAT_W),
    .STEP_W   (STEP_W)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_beat_cnt),
    .i_wdata (in_data),
    .i_step  (r_step_cnt),
    .o_lanes (w_lanes)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= LOAD;
      r_beat_cnt <= '0;
      r_step_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_step_cnt <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_step_nxt  = r_step_cnt;
    unique case (r_state)
      LOAD: begin
        if (w_accept) begin
          if (r_beat_cnt == BEAT_W'(num_rows - 1)) begin
            w_state_nxt = STREAM;
            w_beat_nxt  = '0;
            w_step_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat_cnt + BEAT_W'(1);
          end
        end
      end
      STREAM: begin
        if (r_step_cnt == STEP_W'(S - 1)) begin
          w_state_nxt = LOAD;
          w_step_nxt  = '0;
        end else begin
          w_step_nxt = r_step_cnt + STEP_W'(1);
        end
      end
    endcase
  end

  // Outputs are forced to zero outside STREAM so the array sees zero padding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_stream <= '0;
      r_out_valid  <= 1'b0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
    end else begin
      r_out_stream <= (r_state == STREAM) ? w_lanes : '0;
      r_out_valid  <= (r_state == STREAM);
      r_out_first  <= (r_state == STREAM) && (r_step_cnt == '0);
      r_out_last   <= (r_state == STREAM) && (r_step_cnt == STEP_W'(S - 1));
    end
  end

  assign out_stream = r_out_stream;
  assign out_valid  = r_out_valid;
  assign out_first  = r_out_first;
  assign out_last   = r_out_last;

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Bench for systolic_input_feeder at 4x4: a cycle-level reference model feeds
// a scoreboard of expected wavefront steps, plus directed scenario checks.
module tb_systolic_input_feeder;

  localparam int R = 4;
  localparam int C = 4;
  localparam int S = R + C - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic [8*C-1:0] in_data = '0;
  logic           in_ready;
  logic [8*C-1:0] out_stream;
  logic           out_valid, out_first, out_last, busy;

  always #5 clk = ~clk;

  systolic_input_feeder #(.num_rows(R), .num_cols(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_stream (out_stream),
    .out_valid  (out_valid),
    .out_first  (out_first),
    .out_last   (out_last),
    .busy       (busy)
  );

  typedef struct {
    logic [8*C-1:0] data;
    logic           first;
    logic           last;
    int             due;
  } exp_t;

  exp_t           exp_q[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             m_beats = 0;
  int             m_stall = 0;
  logic [8*C-1:0] m_tile [R];
  logic           m_ready, m_busy;
  int             low_run = 0, nruns = 0, nfirst = 0;

  assign m_ready = (m_stall == 0);
  assign m_busy  = (m_stall != 0) || (m_beats != 0);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8*C-1:0] word(input int r, input logic [7:0] off);
    logic [8*C-1:0] w;
    for (int j = 0; j < C; j++) w[8*j +: 8] = 8'((r << 4) | j) + off;
    return w;
  endfunction

  // Reference model: tile capture, stall window and expected skewed steps.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_beats = 0;
      m_stall = 0;
      exp_q.delete();
    end else if (m_stall > 0) begin
      m_stall--;
    end else if (in_valid) begin
      m_tile[m_beats] = in_data;
      m_beats++;
      if (m_beats == R) begin
        for (int k = 0; k < S; k++) begin
          exp_t e;
          e.data = '0;
          for (int j = 0; j < C; j++)
            if (k - j >= 0 && k - j < R) e.data[8*j +: 8] = m_tile[k-j][8*j +: 8];
          e.first = (k == 0);
          e.last  = (k == S - 1);
          e.due   = cyc + 1 + k;
          exp_q.push_back(e);
        end
        m_beats = 0;
        m_stall = S;
      end
    end
  end

  always @(negedge clk) begin
    logic ev;
    exp_t e;
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("sb_out_valid", 64'(out_valid), 64'(ev));
    if (ev) begin
      e = exp_q.pop_front();
      chk("sb_out_stream", 64'(out_stream), 64'(e.data));
      chk("sb_out_first", 64'(out_first), 64'(e.first));
      chk("sb_out_last", 64'(out_last), 64'(e.last));
    end else begin
      chk("sb_idle_zero", 64'({out_stream, out_first, out_last}), 64'(0));
    end
    chk("sb_in_ready", 64'(in_ready), 64'(m_ready));
    chk("sb_busy", 64'(busy), 64'(m_busy));
  end

  task automatic beat(input int r, input logic [7:0] off);
    in_valid = 1'b1;
    in_data  = word(r, off);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_first(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_first === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic obs3();
    if (in_ready === 1'b0) low_run++;
    else if (low_run > 0) begin
      chk("t3_ready_low_len", 64'(low_run), 64'(S));
      nruns++;
      low_run = 0;
    end
    if (out_first === 1'b1) nfirst++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit             ok;
    int             r, tile, k;
    bit             accepted, stale;
    logic [8*C-1:0] s3;
    bit             pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_stream", 64'(out_stream), 64'(0));
    chk("rst_first_last", 64'({out_first, out_last}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;

    // Test 1: four back-to-back beats.
    for (int i = 0; i < R; i++) beat(i, 8'h00);
    in_valid = 1'b0;
    chk("t1_lat_cycle1", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("t1_lat_cycle2", 64'(out_valid), 64'(1));
    chk("t1_first", 64'(out_first), 64'(1));
    chk("t1_step0", 64'(out_stream), 64'(32'h0000_0000));
    repeat (3) @(negedge clk);
    chk("t1_step3", 64'(out_stream), 64'(32'h0312_2130));
    repeat (3) @(negedge clk);
    chk("t1_step6", 64'(out_stream), 64'(32'h3300_0000));
    chk("t1_last", 64'(out_last), 64'(1));
    chk("t1_ready_at_last", 64'(in_ready), 64'(1));
    @(negedge clk);
    chk("t1_after_burst", 64'(out_valid), 64'(0));
    idle(2);

    // Test 2: gappy in_valid.
    r = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      in_data  = pat[i] ? word(r, 8'h00) : {C{8'hEE}};
      @(negedge clk);
      if (pat[i]) r++;
    end
    in_valid = 1'b0;
    wait_first(ok);
    chk("t2_first_seen", 64'(ok), 64'(1));
    repeat (3) @(negedge clk);
    chk("t2_step3", 64'(out_stream), 64'(32'h0312_2130));
    idle(6);

    // Test 3: three tiles with in_valid held high.
    r = 0;
    tile = 0;
    in_valid = 1'b1;
    while (tile < 3) begin
      in_data  = word(r, 8'(tile * 8'h40));
      accepted = m_ready;
      @(negedge clk);
      obs3();
      if (accepted) begin
        r++;
        if (r == R) begin
          r = 0;
          tile++;
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      obs3();
    end
    chk("t3_low_runs", 64'(nruns), 64'(3));
    chk("t3_bursts", 64'(nfirst), 64'(3));

    // Test 4: reset drops a partial tile.
    beat(0, 8'hA0);
    beat(1, 8'hA0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_ready_after_rst", 64'(in_ready), 64'(1));
    for (int i = 0; i < R; i++) beat(i, 8'h00);
    in_valid = 1'b0;
    stale = 1'b0;
    k = -1;
    s3 = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (out_first === 1'b1) k = 0;
      else if (k >= 0) k++;
      if (k == 3) s3 = out_stream;
      for (int j = 0; j < C; j++)
        if (out_stream[8*j+4 +: 4] === 4'hA) stale = 1'b1;
    end
    chk("t4_no_stale", 64'(stale), 64'(0));
    chk("t4_step3", 64'(s3), 64'(32'h0312_2130));

    // Test 5: reset during stream step 3.
    for (int i = 0; i < R; i++) beat(i, 8'h50);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_valid_cleared", 64'(out_valid), 64'(0));
    chk("t5_stream_cleared", 64'(out_stream), 64'(0));
    chk("t5_ready", 64'(in_ready), 64'(1));
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_last === 1'b1) k++;
      @(negedge clk);
    end
    chk("t5_no_last", 64'(k), 64'(0));

    // Test 6: beats offered during STREAM are ignored.
    for (int i = 0; i < R; i++) beat(i, 8'h10);
    in_valid = 1'b1;
    in_data  = '1;
    for (int i = 0; i < 5; i++) begin
      chk("t6_ready_low", 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    idle(5);
    chk("t6_idle_busy", 64'(busy), 64'(0));

    idle(3);
    chk("sb_queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
